// File: rtl/bsg_fsb_pkg.sv
// Shared definitions for the FSB echo node.
//  - fsb_pkt_s   : 80-bit ring packet {dest, cmd, payload}
//  - FSB_OP_*    : control opcodes carried in payload[7:0]
//  - fsb_state_e : echo-node FSM states
package bsg_fsb_pkg;

    localparam int unsigned FSB_RING_WIDTH = 80;

    typedef struct packed {
        logic [3:0]  dest;
        logic        cmd;      // 0: data, 1: control
        logic [74:0] payload;
    } fsb_pkt_s;

    localparam logic [7:0] FSB_OP_CLEAR  = 8'h01;
    localparam logic [7:0] FSB_OP_REPORT = 8'h02;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_RPT
    } fsb_state_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small single-clock FIFO, one write and one read port, valid/ready on the
// write side and valid/yumi on the read side.
//  clk_i, reset_i : clock, synchronous active-high reset (empties the FIFO)
//  v_i, data_i    : write request and data; written when v_i & ready_o
//  ready_o        : not full
//  v_o, data_o    : not empty, head entry
//  yumi_i         : consume head; only while v_o
module bsg_fifo_1r1w_small #(
    parameter int unsigned width_p = 80,
    parameter int unsigned els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int unsigned ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   rptr_r, wptr_r;
    logic [cnt_w-1:0]   cnt_r;
    logic               enq, deq;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ready_o = (cnt_r != cnt_w'(els_p));
    assign v_o     = (cnt_r != '0);
    assign data_o  = mem[rptr_r];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_r <= '0;
            wptr_r <= '0;
            cnt_r  <= '0;
        end else begin
            if (enq) wptr_r <= ptr_inc(wptr_r);
            if (deq) rptr_r <= ptr_inc(rptr_r);
            case ({enq, deq})
                2'b10:   cnt_r <= cnt_r + 1'b1;
                2'b01:   cnt_r <= cnt_r - 1'b1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem[wptr_r] <= data_i;
    end

endmodule

// File: rtl/bsg_fsb_node_echo.sv
// FSB client node: buffers inbound packets, echoes data packets back to
// master_id_p, and executes clear/report control commands on a count of
// consumed data packets. Unknown opcodes bump a saturating error counter.
//  clk_i, reset_i : core clock, synchronous active-high reset
//  en_i           : node enable; gates ingress only
//  v_i, data_i    : inbound packet, accepted on v_i & ready_o
//  ready_o        : inbound ready
//  v_o, data_o    : outbound packet, held until yumi_i
//  yumi_i         : outbound consume, only while v_o
module bsg_fsb_node_echo
    import bsg_fsb_pkg::*;
#(
    parameter int unsigned ring_width_p = 80,
    parameter int unsigned master_id_p  = 0,
    parameter int unsigned client_id_p  = 0,
    parameter int unsigned fifo_els_p   = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    en_i,
    input  logic                    v_i,
    input  logic [ring_width_p-1:0] data_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [ring_width_p-1:0] data_o,
    input  logic                    yumi_i
);

    fsb_state_e        state_r, state_n;
    fsb_pkt_s          out_r, out_n;
    logic [15:0]       count_r, count_n;
    logic [7:0]        err_r, err_n;

    logic              fifo_ready, fifo_v, fifo_enq, fifo_yumi;
    logic [ring_width_p-1:0] fifo_data;
    logic              take_in, idle, head_v;
    fsb_pkt_s          head;

    assign ready_o = en_i & fifo_ready & ~reset_i;
    assign take_in = v_i & ready_o;
    assign idle    = (state_r == S_IDLE);

    // When idle with an empty buffer, the arriving packet is processed
    // directly instead of being enqueued; this gives the one-cycle
    // accept-to-valid latency while data_o still comes only from out_r.
    assign head_v    = fifo_v | take_in;
    assign head      = fifo_v ? fsb_pkt_s'(fifo_data) : fsb_pkt_s'(data_i);
    assign fifo_enq  = take_in & ~(idle & ~fifo_v);
    assign fifo_yumi = idle & fifo_v;

    bsg_fifo_1r1w_small #(
        .width_p (ring_width_p),
        .els_p   (fifo_els_p)
    ) in_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (fifo_enq),
        .data_i  (data_i),
        .ready_o (fifo_ready),
        .v_o     (fifo_v),
        .data_o  (fifo_data),
        .yumi_i  (fifo_yumi)
    );

    always_comb begin
        state_n = state_r;
        out_n   = out_r;
        count_n = count_r;
        err_n   = err_r;
        unique case (state_r)
            S_IDLE: begin
                if (head_v) begin
                    if (!head.cmd) begin
                        out_n   = '{dest: 4'(master_id_p), cmd: 1'b0, payload: head.payload};
                        state_n = S_SEND;
                    end else begin
                        case (head.payload[7:0])
                            FSB_OP_CLEAR:  count_n = '0;
                            FSB_OP_REPORT: begin
                                out_n   = '{dest: 4'(master_id_p), cmd: 1'b1,
                                            payload: {51'b0, err_r, count_r}};
                                state_n = S_RPT;
                            end
                            default: if (err_r != 8'hFF) err_n = err_r + 8'd1;
                        endcase
                    end
                end
            end
            S_SEND: begin
                if (yumi_i) begin
                    state_n = S_IDLE;
                    count_n = count_r + 16'd1;
                end
            end
            S_RPT: begin
                if (yumi_i) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= S_IDLE;
            out_r   <= '0;
            count_r <= '0;
            err_r   <= '0;
        end else begin
            state_r <= state_n;
            out_r   <= out_n;
            count_r <= count_n;
            err_r   <= err_n;
        end
    end

    assign v_o    = ~idle;
    assign data_o = out_r;

    a_params: assert property (@(posedge clk_i)
        (fifo_els_p >= 2) && (master_id_p < 16) && (client_id_p < 16))
        else $error("bsg_fsb_node_echo: illegal parameters");

    a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
        yumi_i |-> v_o)
        else $error("bsg_fsb_node_echo: yumi_i while v_o=0");

    a_data_stable: assert property (@(posedge clk_i) disable iff (reset_i)
        (v_o && !yumi_i) |=> $stable(data_o))
        else $error("bsg_fsb_node_echo: data_o changed while held");

endmodule

// File: tb/tb_bsg_fsb_node_echo.sv
module tb_bsg_fsb_node_echo;

    localparam logic [3:0] MASTER = 4'h2;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        en_i = 1'b1;
    logic        v_i = 1'b0;
    logic [79:0] data_i = '0;
    logic        ready_o;
    logic        v_o;
    logic [79:0] data_o;
    logic        yumi_i = 1'b0;

    always #5 clk = ~clk;

    bsg_fsb_node_echo #(
        .ring_width_p (80),
        .master_id_p  (2),
        .client_id_p  (5),
        .fifo_els_p   (4)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .en_i    (en_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .yumi_i  (yumi_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] dpkt(input logic [3:0] dest, input logic [74:0] pl);
        return {dest, 1'b0, pl};
    endfunction

    function automatic logic [79:0] ctl(input logic [7:0] op);
        return {4'h1, 1'b1, 67'h0, op};
    endfunction

    function automatic logic [79:0] echo(input logic [74:0] pl);
        return {MASTER, 1'b0, pl};
    endfunction

    function automatic logic [79:0] rpt(input logic [7:0] err, input logic [15:0] cnt);
        return {MASTER, 1'b1, 51'b0, err, cnt};
    endfunction

    // Reference model: packets are interpreted in acceptance order; each one
    // either produces an expected output or updates the counters.
    logic [79:0] exp_q[$];
    logic [15:0] m_cnt = '0;
    logic [7:0]  m_err = '0;

    task automatic model_accept(input logic [79:0] p);
        if (!p[75]) begin
            exp_q.push_back(echo(p[74:0]));
            m_cnt = m_cnt + 16'd1;
        end else if (p[7:0] == 8'h01) begin
            m_cnt = '0;
        end else if (p[7:0] == 8'h02) begin
            exp_q.push_back(rpt(m_err, m_cnt));
        end else if (m_err != 8'hFF) begin
            m_err = m_err + 8'd1;
        end
    endtask

    always @(negedge clk) begin
        if (reset_i) begin
            exp_q.delete();
            m_cnt = '0;
            m_err = '0;
        end else begin
            if (v_o && yumi_i) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %h required no output", data_o);
                end else begin
                    check("sb_order", data_o, exp_q.pop_front());
                end
            end
            if (v_i && ready_o) model_accept(data_i);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset_i = 1'b1;
        v_i     = 1'b0;
        yumi_i  = 1'b0;
        repeat (n) tick();
        reset_i = 1'b0;
    endtask

    logic [79:0] tb_outs[$];

    task automatic drain(input int budget, output int n);
        n = 0;
        tb_outs.delete();
        for (int c = 0; c < budget; c++) begin
            yumi_i = v_o;
            @(negedge clk);
            if (v_o && yumi_i) begin
                tb_outs.push_back(data_o);
                n++;
            end
            tick();
        end
        yumi_i = 1'b0;
    endtask

    function automatic logic [79:0] rand_pkt();
        logic [79:0] p;
        int unsigned r;
        r = $urandom_range(7, 0);
        p = {4'($urandom), 1'b0, 11'($urandom), 32'($urandom), 32'($urandom)};
        if (r >= 5) begin
            p[75] = 1'b1;
            if (r == 5)      p[7:0] = 8'h01;
            else if (r == 6) p[7:0] = 8'h02;
        end
        return p;
    endfunction

    typedef struct {
        string       name;
        logic [79:0] pkt;
        logic        exp_v;
        logic [79:0] exp_data;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, n;

        vecs[0]  = '{"echo",        dpkt(4'h1, 75'h123),   1'b1, echo(75'h123)};
        vecs[1]  = '{"echo_ones",   dpkt(4'hF, '1),        1'b1, echo('1)};
        vecs[2]  = '{"echo_zero",   dpkt(4'h0, '0),        1'b1, echo('0)};
        vecs[3]  = '{"report3",     ctl(8'h02),            1'b1, rpt(8'h00, 16'd3)};
        vecs[4]  = '{"clear",       ctl(8'h01),            1'b0, '0};
        vecs[5]  = '{"report0",     ctl(8'h02),            1'b1, rpt(8'h00, 16'd0)};
        vecs[6]  = '{"bad7f",       ctl(8'h7F),            1'b0, '0};
        vecs[7]  = '{"report_err1", ctl(8'h02),            1'b1, rpt(8'h01, 16'd0)};
        vecs[8]  = '{"echo_5a",     dpkt(4'h9, 75'h5A),    1'b1, echo(75'h5A)};
        vecs[9]  = '{"clear_junk",  {4'h7, 1'b1, 67'h5_DEAD_BEEF, 8'h01}, 1'b0, '0};
        vecs[10] = '{"report_clr",  ctl(8'h02),            1'b1, rpt(8'h01, 16'd0)};
        vecs[11] = '{"bad00",       ctl(8'h00),            1'b0, '0};
        vecs[12] = '{"report_err2", ctl(8'h02),            1'b1, rpt(8'h02, 16'd0)};

        // Reset state
        repeat (4) tick();
        @(negedge clk);
        check("rst_v_o", 80'(v_o), 80'(0));
        check("rst_ready", 80'(ready_o), 80'(0));
        check("rst_data", data_o, '0);
        tick();
        reset_i = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 80'(ready_o), 80'(1));
        tick();

        // Table: one packet at a time; v_o must appear the cycle after acceptance
        for (int i = 0; i < 13; i++) begin
            v_i    = 1'b1;
            data_i = vecs[i].pkt;
            yumi_i = 1'b0;
            @(negedge clk);
            check($sformatf("%s_rdy", vecs[i].name), 80'(ready_o), 80'(1));
            tick();
            v_i = 1'b0;
            @(negedge clk);
            check($sformatf("%s_v", vecs[i].name), 80'(v_o), 80'(vecs[i].exp_v));
            if (vecs[i].exp_v) check($sformatf("%s_data", vecs[i].name), data_o, vecs[i].exp_data);
            tick();
            if (v_o) begin
                yumi_i = 1'b1;
                tick();
                yumi_i = 1'b0;
            end
        end

        // Backpressure: 4 in FIFO + 1 in output register
        do_reset(2);
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            v_i    = 1'b1;
            data_i = dpkt(4'h3, 75'(100 + i));
            @(negedge clk);
            if (ready_o) acc++;
            tick();
        end
        v_i = 1'b0;
        @(negedge clk);
        check("bp_accepted", 80'(acc), 80'(5));
        check("bp_ready_full", 80'(ready_o), 80'(0));
        tick();
        drain(30, n);
        check("bp_out_count", 80'(n), 80'(5));
        for (int k = 0; k < tb_outs.size(); k++)
            check($sformatf("bp_out%0d", k), tb_outs[k], echo(75'(100 + k)));

        // Enable gating: ingress blocked, buffered packets still drain
        do_reset(2);
        for (int i = 0; i < 3; i++) begin
            v_i    = 1'b1;
            data_i = dpkt(4'h4, 75'(200 + i));
            tick();
        end
        data_i = dpkt(4'h4, 75'(299));
        en_i   = 1'b0;
        @(negedge clk);
        check("en_ready_low", 80'(ready_o), 80'(0));
        tick();
        v_i = 1'b0;
        drain(20, n);
        check("en_out_count", 80'(n), 80'(3));
        for (int k = 0; k < tb_outs.size(); k++)
            check($sformatf("en_out%0d", k), tb_outs[k], echo(75'(200 + k)));
        en_i = 1'b1;

        // Reset while holding an output with 3 buffered
        do_reset(2);
        for (int i = 0; i < 2; i++) begin
            v_i    = 1'b1;
            data_i = dpkt(4'h5, 75'(300 + i));
            tick();
        end
        v_i = 1'b0;
        drain(10, n);
        check("mid_pre_count", 80'(n), 80'(2));
        for (int i = 0; i < 4; i++) begin
            v_i    = 1'b1;
            data_i = dpkt(4'h6, 75'(400 + i));
            tick();
        end
        v_i = 1'b0;
        @(negedge clk);
        check("mid_v_held", 80'(v_o), 80'(1));
        tick();
        reset_i = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 80'(ready_o), 80'(0));
        tick();
        @(negedge clk);
        check("mid_rst_v", 80'(v_o), 80'(0));
        check("mid_rst_data", data_o, '0);
        tick();
        reset_i = 1'b0;
        v_i     = 1'b1;
        data_i  = ctl(8'h02);
        tick();
        v_i = 1'b0;
        @(negedge clk);
        check("mid_rpt_v", 80'(v_o), 80'(1));
        check("mid_rpt_data", data_o, rpt(8'h00, 16'd0));
        tick();
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("mid_fifo_empty", 80'(v_o), 80'(0));
        tick();

        // Error counter saturation
        do_reset(2);
        v_i    = 1'b1;
        data_i = ctl(8'h7F);
        repeat (300) tick();
        data_i = ctl(8'h02);
        tick();
        v_i = 1'b0;
        @(negedge clk);
        check("sat_v", 80'(v_o), 80'(1));
        check("sat_rpt", data_o, rpt(8'hFF, 16'd0));
        tick();
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;

        // Randomized traffic against the reference model
        do_reset(2);
        for (int c = 0; c < 3000; c++) begin
            en_i    = ($urandom_range(7, 0) != 0);
            v_i     = 1'($urandom);
            data_i  = rand_pkt();
            reset_i = ($urandom_range(299, 0) == 0);
            yumi_i  = v_o && !reset_i && ($urandom_range(2, 0) != 0);
            tick();
        end
        reset_i = 1'b0;
        v_i     = 1'b0;
        en_i    = 1'b1;
        drain(60, n);
        check("rand_leftover", 80'(exp_q.size()), 80'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
